sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
Memory-side responder for the core's instruction/data request port: accepts one read or write request over a valid/ready handshake, then returns a response after a fixed access latency. Backed by an internal word-addressed array mapped at BASE. Lets the core's fetch/load/store path move from the ideal combinational memory model to a timed handshake with stalls. Only one transaction is outstanding at a time.

Parameters:
DEPTH_LOG2, 12, log2 of the array depth in 32-bit words (default is 16 KiB).
LATENCY, 1, number of cycles from the request-accept edge to rsp_valid rising; legal range 1..15.
BASE, 32'h80000000, byte address of word 0 of the array.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_addr  in  32  byte address; bits [1:0] ignored
req_wen  in  1  1 = write, 0 = read
req_wdata  in  32  write data, lane-aligned
req_wmask  in  4  byte-lane write enables; bit i controls wdata[8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts the response
rsp_rdata  out  32  read data (full word); 0 for writes and errors
rsp_err  out  1  address outside the array

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 while reset is held. Array contents are not reset. An in-flight transaction is dropped, and a write whose commit edge has not yet occurred is not committed.
- First edge with rst==1: req_ready=1.
- States:
  - IDLE: req_ready=1. When req_valid && req_ready at an edge, latch addr/wen/wdata/wmask, load cnt=LATENCY-1, then go to WAIT.
  - WAIT: req_ready=0. While cnt!=0, decrement cnt. When cnt==0, at that edge perform the access (array write commit, or register the read data), register rsp_err, then go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready==1 at an edge, then go to IDLE. rsp_valid falls and req_ready rises after that edge.
- Timing: with accept at edge k, rsp_valid is high after edge k+LATENCY. Minimum round trip for LATENCY=1 is 3 cycles: accept, access, response handshake.
- No back-to-back acceptance: req_ready is low from the accept edge until the response handshake edge.
- Address decode:
  - off = req_addr - BASE (32-bit wrap); index = off[DEPTH_LOG2+1:2].
  - In range iff off < 4*2^DEPTH_LOG2 (unsigned). Addresses below BASE wrap to a large off and are out of range.
- Out of range: no array write, rsp_rdata=0, rsp_err=1.
- Write: only lanes with wmask bit set are updated. wmask=0 is a legal no-op write. rsp_rdata=0, rsp_err=0.
- Read: rsp_rdata = full word at index. Byte/half extraction and sign extension are the requester's job.
- req_addr/req_wdata/req_wen/req_wmask are sampled only at the accept edge. Changes on these inputs while the responder is busy are ignored.
- rsp_ready held high before rsp_valid rises is legal; the response then completes on the first edge rsp_valid is high.
- Read-after-write to the same word in consecutive transactions returns the new data.

Optional Feature:
SRAM_RSP_RANDDELAY_EN:
- When defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 at reset and advances once per accepted request. extra = lfsr[1:0], sampled at the accept edge, giving cnt = LATENCY-1+extra (0..3 extra wait cycles). This exercises the requester's stall handling deterministically.
- When undefined: no LFSR is built and latency is exactly LATENCY.

Test Plan:
1. Reset then write 32'hDEADBEEF to 32'h80000010 (wmask 4'hF, LATENCY=1), then read the same address -> rsp_err=0, rsp_rdata=32'hDEADBEEF; rsp_valid high exactly 1 edge after each accept.
2. Partial write: word holds 32'h11223344; write wdata 32'hAABBCCDD with wmask 4'b0101 -> read returns 32'h11BB33DD.
3. Out of range: read 32'h7FFFFFFC and write 32'h80004000 (DEPTH_LOG2=12) -> rsp_err=1, rsp_rdata=0; a subsequent read of 32'h80000000 is unchanged.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata/rsp_err stable, req_ready=0, and a second req_valid is not accepted until one edge after rsp_ready=1.
5. LATENCY=4: accept at edge k -> rsp_valid low through edge k+3, high after edge k+4.
6. Reset mid-op: accept a write to 32'h80000020 of 32'h12345678 with LATENCY=3 and pull rst low at edge k+1 -> outputs clear and req_ready=0 during reset; after release, a read returns the prior contents with no commit.

Source files
------------

// File: rtl/sram_responder.sv
// Timed valid/ready memory responder backed by a word-addressed array at BASE.
// Optional SRAM_RSP_RANDDELAY_EN adds 0..3 LFSR-chosen extra wait cycles per request.
module sram_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE       = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_next;
    logic                  ready_en;
    logic [4:0]            cnt;
    logic [4:0]            extra;
    logic [4:0]            cnt_load;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  wen_q;
    logic                  oor_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [31:0]           off;
    logic                  in_range;
    logic                  accept;
    logic                  access;
    logic [31:0]           mem [DEPTH];

    // Addresses below BASE wrap to a huge offset and so fall out of range.
    assign off      = req_addr - BASE;
    assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign accept   = req_valid && req_ready;
    assign access   = rst && (state == WAIT) && (cnt == 5'd0);

`ifdef SRAM_RSP_RANDDELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    assign cnt_load = 5'(LATENCY - 1) + extra;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)         state_next = WAIT;
            WAIT:    if (cnt == 5'd0)    state_next = RESP;
            RESP:    if (rsp_ready)      state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // ready_en keeps req_ready low until the first edge after reset is released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_en <= 1'b0;
            cnt      <= 5'd0;
            idx_q    <= '0;
            wen_q    <= 1'b0;
            oor_q    <= 1'b0;
            wdata_q  <= 32'd0;
            wmask_q  <= 4'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                idx_q   <= DEPTH_LOG2'(off >> 2);
                oor_q   <= !in_range;
                wen_q   <= req_wen;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
                cnt     <= cnt_load;
            end else if (state == WAIT && cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end
            if (access) begin
                err_q   <= oor_q;
                rdata_q <= (oor_q || wen_q) ? 32'd0 : mem[idx_q];
            end
        end
    end

    // NOTE: the array has no reset; clearing it would prevent mapping it onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (access && wen_q && !oor_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign req_ready = ready_en && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: three instances with LATENCY 1, 4 and 3.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wmask [3];
    logic [31:0] rsp_rdata [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 4 : 3;
        sram_responder #(
            .DEPTH_LOG2(12),
            .LATENCY   (LAT),
            .BASE      (32'h80000000)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .req_wen  (req_wen[g]),
            .req_wdata(req_wdata[g]),
            .req_wmask(req_wmask[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; request inputs are scrambled after accept.
    task automatic xact(input int i, input int lat, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        check({tag, " idle_ready"}, 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_wen[i]   = wen;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wmask[i] = wmask;
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_wen[i]   = ~wen;
        req_addr[i]  = ~addr;
        req_wdata[i] = ~wdata;
        req_wmask[i] = ~wmask;
        check({tag, " busy_ready"}, 32'(req_ready[i]), 32'd0);
        n = 0;
        while (!rsp_valid[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " rdata"}, rsp_rdata[i], exp_rdata);
        check({tag, " err"}, 32'(rsp_err[i]), 32'(exp_err));
        @(negedge clk);
        check({tag, " valid_drop"}, 32'(rsp_valid[i]), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_wen[i]   = 1'b0;
            rsp_ready[i] = 1'b1;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            req_wmask[i] = 4'd0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(req_ready[0]), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst rsp_rdata", rsp_rdata[0], 32'd0);
        check("rst rsp_err", 32'(rsp_err[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel req_ready", 32'(req_ready[0]), 32'd1);

        // Basic write then read
        xact(0, 1, 1'b1, 32'h80000010, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, "t1_wr");
        xact(0, 1, 1'b0, 32'h80000010, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "t1_rd");

        // Partial write by byte lanes
        xact(0, 1, 1'b1, 32'h80000040, 32'h11223344, 4'hF, 32'd0, 1'b0, "t2_wr");
        xact(0, 1, 1'b1, 32'h80000040, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0, "t2_pwr");
        xact(0, 1, 1'b0, 32'h80000040, 32'd0, 4'h0, 32'h11BB33DD, 1'b0, "t2_rd");

        // Out of range and the array edges
        xact(0, 1, 1'b1, 32'h80000000, 32'h01020304, 4'hF, 32'd0, 1'b0, "t3_wr0");
        xact(0, 1, 1'b0, 32'h7FFFFFFC, 32'd0, 4'h0, 32'd0, 1'b1, "t3_rd_low");
        xact(0, 1, 1'b1, 32'h80004000, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, "t3_wr_high");
        xact(0, 1, 1'b0, 32'h80000000, 32'd0, 4'h0, 32'h01020304, 1'b0, "t3_rd0");
        xact(0, 1, 1'b1, 32'h80003FFC, 32'h5A5A5A5A, 4'hF, 32'd0, 1'b0, "t3_wr_last");
        xact(0, 1, 1'b0, 32'h80003FFC, 32'd0, 4'h0, 32'h5A5A5A5A, 1'b0, "t3_rd_last");

        // Backpressure with a second request waiting
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_wen[0]   = 1'b0;
        req_addr[0]  = 32'h80000010;
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        req_addr[0] = 32'h80000040;
        check("t4 busy_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("t4 hold_valid", 32'(rsp_valid[0]), 32'd1);
            check("t4 hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
            check("t4 hold_err", 32'(rsp_err[0]), 32'd0);
            check("t4 hold_ready", 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        check("t4 still_valid", 32'(rsp_valid[0]), 32'd1);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("t4 hs_valid", 32'(rsp_valid[0]), 32'd0);
        check("t4 hs_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("t4 second_accept", 32'(req_ready[0]), 32'd0);
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4 second_latency", 32'(n), 32'd1);
        check("t4 second_rdata", rsp_rdata[0], 32'h11BB33DD);
        @(negedge clk);
        check("t4 second_drop", 32'(rsp_valid[0]), 32'd0);

        // LATENCY=4 instance
        xact(1, 4, 1'b1, 32'h80000100, 32'hCAFE0001, 4'hF, 32'd0, 1'b0, "t5_wr");
        xact(1, 4, 1'b0, 32'h80000100, 32'd0, 4'h0, 32'hCAFE0001, 1'b0, "t5_rd");

        // Reset during an in-flight write on the LATENCY=3 instance
        xact(2, 3, 1'b1, 32'h80000020, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, "t6_pre_wr");
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_wen[2]   = 1'b1;
        req_addr[2]  = 32'h80000020;
        req_wdata[2] = 32'h12345678;
        req_wmask[2] = 4'hF;
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("t6 busy_ready", 32'(req_ready[2]), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6 rst_ready", 32'(req_ready[2]), 32'd0);
            check("t6 rst_valid", 32'(rsp_valid[2]), 32'd0);
            check("t6 rst_rdata", rsp_rdata[2], 32'd0);
            check("t6 rst_err", 32'(rsp_err[2]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("t6 rel_ready", 32'(req_ready[2]), 32'd1);
        xact(2, 3, 1'b0, 32'h80000020, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0, "t6_rd");
        xact(0, 1, 1'b0, 32'h80000010, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "t6_keep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
